// File: rtl/sseg_arb_pkg.sv
// Shared types, defaults and the round-robin select helper for the display arbiter.
package sseg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        HOLD
    } arb_state_t;

    localparam logic [15:0] IDLE_DATA_DEFAULT = 16'hBBBB;

    // First requesting index after last_idx, wrapping; last_idx itself is checked last.
    function automatic logic [2:0] rr_select(input logic [7:0] req,
                                             input logic [2:0] last_idx,
                                             input int         n_clients);
        logic [2:0] sel;
        logic [2:0] idx;
        sel = last_idx;
        for (int i = 8; i >= 1; i--) begin
            if (i <= n_clients) begin
                idx = 3'((int'(last_idx) + i) % n_clients);
                if (req[idx]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running millisecond prescaler: tick is high for the last cycle of each period.
module ms_tick #(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_arbiter.sv
// Round-robin owner of the seven-segment display with a minimum dwell per grant.
// Define SSEG_ARB_PRIORITY0_EN to let client 0 preempt any other grant.
module sseg_arbiter
    import sseg_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS  = 4,
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned DWELL_MS   = 500,
    parameter logic [15:0] IDLE_DATA  = IDLE_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [N_CLIENTS-1:0]    req,
    input  logic [16*N_CLIENTS-1:0] data,
    output logic [N_CLIENTS-1:0]    grant,
    output logic [15:0]             display_data,
    output logic                    busy,
    output logic                    switch_pulse
);

    localparam int unsigned DW_W = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_MS);

    arb_state_t             state_q, state_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [2:0]             last_idx_q, last_idx_d;
    logic [DW_W-1:0]        dwell_q, dwell_d;
    logic [15:0]            display_q, display_d;
    logic                   busy_q;
    logic                   switch_q;

    logic       tick;
    logic [2:0] sel;
    logic [2:0] next_idx;
    logic       new_grant;
    logic       prio_hit;
    logic       req_g;
    logic       others;
    logic       expired;

    ms_tick #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ms_tick (
        .clk  (clk),
        .clear(clear),
        .tick (tick)
    );

    // In HOLD the granted index always equals last_idx_q.
    assign sel     = rr_select(8'(req), last_idx_q, int'(N_CLIENTS));
    assign req_g   = |(req & grant_q);
    assign others  = |(req & ~grant_q);
    assign expired = (dwell_q >= DWELL_MAX);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        dwell_d    = dwell_q;
        next_idx   = sel;
        new_grant  = 1'b0;
        prio_hit   = 1'b0;
`ifdef SSEG_ARB_PRIORITY0_EN
        prio_hit   = (state_q == HOLD) && req[0] && (last_idx_q != 3'd0);
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                end
            end
            HOLD: begin
                if (tick && (dwell_q < DWELL_MAX)) begin
                    dwell_d = dwell_q + 1'b1;
                end
                if (prio_hit) begin
                    new_grant = 1'b1;
                    next_idx  = 3'd0;
                end else if (!req_g) begin
                    if (|req) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (expired && others) begin
                    new_grant = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (new_grant) begin
            state_d    = HOLD;
            last_idx_d = next_idx;
            dwell_d    = '0;
            for (int i = 0; i < int'(N_CLIENTS); i++) begin
                grant_d[i] = (next_idx == 3'(i));
            end
        end

        // Display always reflects the owner chosen for the coming cycle.
        display_d = IDLE_DATA;
        for (int i = 0; i < int'(N_CLIENTS); i++) begin
            if (grant_d[i]) begin
                display_d = data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_idx_q <= 3'(N_CLIENTS - 1);
            dwell_q    <= '0;
            display_q  <= IDLE_DATA;
            busy_q     <= 1'b0;
            switch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            dwell_q    <= dwell_d;
            display_q  <= display_d;
            busy_q     <= |grant_d;
            switch_q   <= (grant_d != grant_q);
        end
    end

    assign grant        = grant_q;
    assign display_data = display_q;
    assign busy         = busy_q;
    assign switch_pulse = switch_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Self-checking bench for sseg_arbiter with a cycle-level behavioural model.
module tb_sseg_arbiter;

    localparam int N   = 4;
    localparam int CPM = 10;
    localparam int DW  = 3;
    localparam logic [15:0] IDLE_W = 16'hBBBB;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic [N-1:0]     req = '0;
    logic [16*N-1:0]  data = '0;
    logic [N-1:0]     grant;
    logic [15:0]      display_data;
    logic             busy;
    logic             switch_pulse;

    int tests = 0;
    int fails = 0;

    // Model state: owner index (-1 = nobody), last owner, dwell ms, prescaler count.
    int          m_g = -1;
    int          m_last = N - 1;
    int          m_dwell = 0;
    int          m_pre = 0;
    logic [15:0] m_disp = IDLE_W;
    logic        m_pulse = 1'b0;

    always #5 clk = ~clk;

    sseg_arbiter #(
        .N_CLIENTS (N),
        .CLK_PER_MS(CPM),
        .DWELL_MS  (DW),
        .IDLE_DATA (IDLE_W)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .req         (req),
        .data        (data),
        .grant       (grant),
        .display_data(display_data),
        .busy        (busy),
        .switch_pulse(switch_pulse)
    );

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        return (m_g < 0) ? '0 : (N'(1) << m_g);
    endfunction

    task automatic model_edge();
        int ng;
        bit tk;
        logic [N-1:0] oth;
        if (clear) begin
            m_g = -1; m_last = N - 1; m_dwell = 0; m_pre = 0;
            m_disp = IDLE_W; m_pulse = 1'b0;
            return;
        end
        tk = (m_pre == CPM - 1);
        m_pre = tk ? 0 : m_pre + 1;
        if (m_g < 0) begin
            ng = (req != 0) ? pick(req, m_last) : -1;
        end else begin
            oth = req;
            oth[m_g] = 1'b0;
            ng = m_g;
            if (!req[m_g]) ng = (req != 0) ? pick(req, m_last) : -1;
            else if (m_dwell >= DW && oth != 0) ng = pick(req, m_last);
`ifdef SSEG_ARB_PRIORITY0_EN
            if (req[0] && m_g != 0) ng = 0;
`endif
            if (tk && m_dwell < DW) m_dwell++;
        end
        m_pulse = (ng != m_g);
        if (ng >= 0 && ng != m_g) begin
            m_last = ng;
            m_dwell = 0;
        end
        m_g = ng;
        m_disp = (ng < 0) ? IDLE_W : data[16*ng +: 16];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req = '1;
        data = {16'hDDDD, 16'hCCCC, 16'h5678, 16'h1234};
        for (int c = 0; c < 2; c++) begin
            step();
            tests++;
            if (grant !== '0 || display_data !== 16'hBBBB || busy !== 1'b0
                || switch_pulse !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold c=%0d got g=%b d=%h b=%b p=%b want 0000 bbbb 0 0",
                         c, grant, display_data, busy, switch_pulse);
            end
        end
        clear = 1'b0;
        step();
        tests++;
        if (grant !== 4'b0001 || display_data !== 16'h1234 || switch_pulse !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant got g=%b d=%h p=%b want 0001 1234 1",
                     grant, display_data, switch_pulse);
        end
    endtask

    task automatic test_dwell_rotation();
        int chg_at[$];
        logic [N-1:0] chg_to[$];
        logic [N-1:0] prev;
        do_clear();
        prev = grant;
        req = 4'b0101;
        for (int c = 1; c <= 70; c++) begin
            step();
            tests++;
            if (switch_pulse !== (grant !== prev)) begin
                fails++;
                $display("FAIL dwell_pulse c=%0d got %b want %b", c, switch_pulse, grant !== prev);
            end
            tests++;
            if (grant !== m_grant() || display_data !== m_disp) begin
                fails++;
                $display("FAIL dwell_model c=%0d got g=%b d=%h want g=%b d=%h",
                         c, grant, display_data, m_grant(), m_disp);
            end
            if (grant !== prev) begin
                chg_at.push_back(c);
                chg_to.push_back(grant);
            end
            prev = grant;
        end
        tests++;
        if (chg_at.size() != 3 || chg_at[0] != 1 || chg_at[1] != 31 || chg_at[2] != 61
            || chg_to[0] !== 4'b0001 || chg_to[1] !== 4'b0100 || chg_to[2] !== 4'b0001) begin
            fails++;
            $display("FAIL dwell_schedule got %0d changes first at %0d want 3 changes at 1,31,61",
                     chg_at.size(), (chg_at.size() > 0) ? chg_at[0] : -1);
        end
    endtask

    task automatic test_early_release();
        int held;
        do_clear();
        req = 4'b0100;
        repeat (4) step();
        req = 4'b0110;
        step();
        req = 4'b0010;
        step();
        tests++;
        if (grant !== 4'b0010 || busy !== 1'b1 || switch_pulse !== 1'b1) begin
            fails++;
            $display("FAIL early_release got g=%b b=%b p=%b want 0010 1 1",
                     grant, busy, switch_pulse);
        end
        req = 4'b1010;
        held = 1;
        for (int c = 0; c < 60 && grant === 4'b0010; c++) begin
            step();
            if (grant === 4'b0010) held++;
        end
        tests++;
        if (held != 25 || grant !== 4'b1000) begin
            fails++;
            $display("FAIL early_dwell got held=%0d g=%b want 25 1000", held, grant);
        end
    endtask

    task automatic test_all_drop();
        do_clear();
        req = 4'b0010;
        repeat (2) step();
        req = 4'b0000;
        step();
        tests++;
        if (grant !== '0 || busy !== 1'b0 || display_data !== 16'hBBBB
            || switch_pulse !== 1'b1) begin
            fails++;
            $display("FAIL all_drop got g=%b b=%b d=%h p=%b want 0000 0 bbbb 1",
                     grant, busy, display_data, switch_pulse);
        end
        req = 4'b1000;
        step();
        tests++;
        if (grant !== 4'b1000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL regrant_3 got g=%b b=%b want 1000 1", grant, busy);
        end
    endtask

    task automatic test_data_tracking();
        data[63:48] = 16'h0042;
        step();
        tests++;
        if (display_data !== 16'h0042) begin
            fails++;
            $display("FAIL data_track_a got %h want 0042", display_data);
        end
        data[63:48] = 16'h0999;
        tests++;
        if (display_data !== 16'h0042) begin
            fails++;
            $display("FAIL data_latency got %h want 0042", display_data);
        end
        step();
        tests++;
        if (display_data !== 16'h0999) begin
            fails++;
            $display("FAIL data_track_b got %h want 0999", display_data);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] want;
        do_clear();
        req = 4'b0100;
        repeat (10) step();
        req = 4'b0101;
        step();
`ifdef SSEG_ARB_PRIORITY0_EN
        want = 4'b0001;
`else
        want = 4'b0100;
`endif
        tests++;
        if (grant !== want || grant !== m_grant()) begin
            fails++;
            $display("FAIL priority got g=%b want %b", grant, want);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            clear = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
            step();
            tests++;
            if (grant !== m_grant() || busy !== (m_g >= 0) || switch_pulse !== m_pulse
                || display_data !== m_disp) begin
                fails++;
                $display("FAIL random c=%0d got g=%b b=%b p=%b d=%h want g=%b b=%b p=%b d=%h",
                         c, grant, busy, switch_pulse, display_data,
                         m_grant(), m_g >= 0, m_pulse, m_disp);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dwell_rotation();
        test_early_release();
        test_all_drop();
        test_data_tracking();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
